onewire_reset_presence_monitor: RTL and testbench

//  Parametrised 1-Wire bus timing monitor, successor to the single-threshold reset check.

---
 rtl/onewire_pkg.sv | 26 ++
 rtl/onewire_sync.sv | 35 +++
 rtl/onewire_reset_presence_monitor.sv | 167 ++++++++++++++++
 tb/tb_onewire_reset_presence_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared 1-Wire definitions: FSM state codes, default bus timing in
// microseconds, and a helper that converts microseconds to clock ticks.
// No ports.
package onewire_pkg;

    // Default 1-Wire standard-speed timing, in microseconds.
    localparam int RST_MIN_US_DFLT  = 480;
    localparam int RST_MAX_US_DFLT  = 960;
    localparam int PDLY_MIN_US_DFLT = 15;
    localparam int PDLY_MAX_US_DFLT = 60;
    localparam int PLOW_MIN_US_DFLT = 60;
    localparam int PLOW_MAX_US_DFLT = 240;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOW     = 3'd1;
    localparam state_t ST_WAIT_PD = 3'd2;
    localparam state_t ST_PRES    = 3'd3;
    localparam state_t ST_STUCK   = 3'd4;

    function automatic int ticks(input int us, input int clk_per_us);
        return us * clk_per_us;
    endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchroniser for the raw 1-Wire line plus falling-edge detect.
// All flops reset to 1 (idle-high bus), so a line already low at reset
// shows up as a fall once reset is released.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   bus    in   raw asynchronous line level
//   bus_s  out  synchronised line level (2 cycles after the pin)
//   fall   out  1 when bus_s has just gone from 1 to 0
module onewire_sync (
    input  logic clk,
    input  logic rst,
    input  logic bus,
    output logic bus_s,
    output logic fall
);

    logic meta;
    logic bus_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b1;
            bus_s <= 1'b1;
            bus_p <= 1'b1;
        end else begin
            meta  <= bus;
            bus_s <= meta;
            bus_p <= bus_s;
        end
    end

    assign fall = bus_p & ~bus_s;

endmodule

// File: rtl/onewire_reset_presence_monitor.sv
// 1-Wire reset/presence timing monitor. Measures each bus low period,
// recognises a valid reset pulse, then times the slave presence pulse and
// flags missing/malformed presence and a stuck-low bus.
// Ports:
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   bus             in   raw 1-Wire line (asynchronous)
//   en_check        in   monitor enable, 0 holds the FSM in IDLE
//   reset_found     out  1-cycle pulse, valid reset low ended
//   presence_found  out  1-cycle pulse, valid presence pulse ended
//   no_presence     out  1-cycle pulse, no presence fall in time
//   pres_err        out  1-cycle pulse, presence too early/short/long
//   stuck_low       out  1-cycle pulse, bus low longer than reset max
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for a bus fall
// ST_LOW     | timing a low period (reset candidate or time slot)
// ST_WAIT_PD | reset released, timing the gap to the presence fall
// ST_PRES    | timing the presence low
// ST_STUCK   | fault seen, waiting for the bus to return high
module onewire_reset_presence_monitor
    import onewire_pkg::*;
#(
    parameter int CLK_PER_US  = 1,
    parameter int RST_MIN_US  = RST_MIN_US_DFLT,
    parameter int RST_MAX_US  = RST_MAX_US_DFLT,
    parameter int PDLY_MIN_US = PDLY_MIN_US_DFLT,
    parameter int PDLY_MAX_US = PDLY_MAX_US_DFLT,
    parameter int PLOW_MIN_US = PLOW_MIN_US_DFLT,
    parameter int PLOW_MAX_US = PLOW_MAX_US_DFLT
) (
    input  logic clk,
    input  logic rst,
    input  logic bus,
    input  logic en_check,
    output logic reset_found,
    output logic presence_found,
    output logic no_presence,
    output logic pres_err,
    output logic stuck_low
);

    localparam int CNT_W = $clog2(RST_MAX_US * CLK_PER_US + 2);

    localparam logic [CNT_W-1:0] T_RST_MIN  = CNT_W'(ticks(RST_MIN_US, CLK_PER_US));
    localparam logic [CNT_W-1:0] T_RST_MAX  = CNT_W'(ticks(RST_MAX_US, CLK_PER_US));
    localparam logic [CNT_W-1:0] T_PDLY_MIN = CNT_W'(ticks(PDLY_MIN_US, CLK_PER_US));
    localparam logic [CNT_W-1:0] T_PDLY_MAX = CNT_W'(ticks(PDLY_MAX_US, CLK_PER_US));
    localparam logic [CNT_W-1:0] T_PLOW_MIN = CNT_W'(ticks(PLOW_MIN_US, CLK_PER_US));
    localparam logic [CNT_W-1:0] T_PLOW_MAX = CNT_W'(ticks(PLOW_MAX_US, CLK_PER_US));
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic       bus_s;
    logic       fall;
    state_t     state;
    logic [CNT_W-1:0] cnt;

    onewire_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .bus_s (bus_s),
        .fall  (fall)
    );

    // cnt holds the number of qualifying samples already seen in the
    // current state, so "cnt == MAX" on one more qualifying sample means
    // the count has just reached MAX+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            reset_found    <= 1'b0;
            presence_found <= 1'b0;
            no_presence    <= 1'b0;
            pres_err       <= 1'b0;
            stuck_low      <= 1'b0;
        end else begin
            reset_found    <= 1'b0;
            presence_found <= 1'b0;
            no_presence    <= 1'b0;
            pres_err       <= 1'b0;
            stuck_low      <= 1'b0;
            if (!en_check) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Needs a real fall: a line already low is ignored.
                        if (fall) begin
                            state <= ST_LOW;
                            cnt   <= CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (!bus_s) begin
                            if (cnt == T_RST_MAX) begin
                                stuck_low <= 1'b1;
                                state     <= ST_STUCK;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else if (cnt >= T_RST_MIN) begin
                            reset_found <= 1'b1;
                            state       <= ST_WAIT_PD;
                            cnt         <= CNT_ONE;
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    ST_WAIT_PD: begin
                        if (bus_s) begin
                            if (cnt == T_PDLY_MAX) begin
                                no_presence <= 1'b1;
                                state       <= ST_IDLE;
                                cnt         <= '0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else if (cnt >= T_PDLY_MIN) begin
                            state <= ST_PRES;
                            cnt   <= CNT_ONE;
                        end else begin
                            pres_err <= 1'b1;
                            state    <= ST_STUCK;
                            cnt      <= '0;
                        end
                    end
                    ST_PRES: begin
                        if (!bus_s) begin
                            if (cnt == T_PLOW_MAX) begin
                                pres_err <= 1'b1;
                                state    <= ST_STUCK;
                                cnt      <= '0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else begin
                            if (cnt >= T_PLOW_MIN) begin
                                presence_found <= 1'b1;
                            end else begin
                                pres_err <= 1'b1;
                            end
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    ST_STUCK: begin
                        if (bus_s) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_onewire_reset_presence_monitor.sv
// Bench for onewire_reset_presence_monitor (CLK_PER_US = 1).
// Stimulus is a list of alternating line segment lengths (high first).
// A duration-level reference model turns the list into expected pulses
// (kind + cycle) pushed onto a scoreboard queue; a negedge monitor pops
// and compares whenever the DUT pulses any output.
module tb_onewire_reset_presence_monitor;

    localparam int T_RST_MIN  = 480;
    localparam int T_RST_MAX  = 960;
    localparam int T_PDLY_MIN = 15;
    localparam int T_PDLY_MAX = 60;
    localparam int T_PLOW_MIN = 60;
    localparam int T_PLOW_MAX = 240;

    localparam int K_RST   = 0;
    localparam int K_PRES  = 1;
    localparam int K_NOP   = 2;
    localparam int K_PERR  = 3;
    localparam int K_STUCK = 4;

    localparam int NO_CUT = 32'h3fff_ffff;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   segs[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bus = 1'b1;
    logic en_check = 1'b1;
    logic reset_found, presence_found, no_presence, pres_err, stuck_low;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    onewire_reset_presence_monitor #(
        .CLK_PER_US  (1),
        .RST_MIN_US  (480),
        .RST_MAX_US  (960),
        .PDLY_MIN_US (15),
        .PDLY_MAX_US (60),
        .PLOW_MIN_US (60),
        .PLOW_MAX_US (240)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .en_check       (en_check),
        .reset_found    (reset_found),
        .presence_found (presence_found),
        .no_presence    (no_presence),
        .pres_err       (pres_err),
        .stuck_low      (stuck_low)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin sample n driven at cycle base+n is decided by the FSM two cycles
    // later and its pulse is visible one cycle after that.
    task automatic push_ev(input int kind, input int idx, input int base, input int cut);
        exp_t e;
        if (idx < cut) begin
            e.kind = kind;
            e.cyc  = base + idx + 3;
            exp_q.push_back(e);
        end
    endtask

    // Reference model over segment durations. mode: 0 idle, 1 gap after a
    // valid reset, 3 presence fall came too early, 4 presence low expected.
    task automatic model(input int base, input int cut);
        int pos;
        int mode;
        int s;
        int l;
        pos  = 0;
        mode = 0;
        for (int i = 0; i < segs.size(); i++) begin
            s = pos;
            l = segs[i];
            if (i % 2 == 0) begin
                if (mode == 1) begin
                    if (l > T_PDLY_MAX) begin
                        push_ev(K_NOP, s + T_PDLY_MAX, base, cut);
                        mode = 0;
                    end else if (l < T_PDLY_MIN) begin
                        mode = 3;
                    end else begin
                        mode = 4;
                    end
                end else begin
                    mode = 0;
                end
            end else begin
                if (mode == 3) begin
                    push_ev(K_PERR, s, base, cut);
                    mode = 0;
                end else if (mode == 4) begin
                    if (l > T_PLOW_MAX) push_ev(K_PERR, s + T_PLOW_MAX, base, cut);
                    else if (l >= T_PLOW_MIN) push_ev(K_PRES, s + l, base, cut);
                    else push_ev(K_PERR, s + l, base, cut);
                    mode = 0;
                end else begin
                    if (l > T_RST_MAX) begin
                        push_ev(K_STUCK, s + T_RST_MAX, base, cut);
                    end else if (l >= T_RST_MIN) begin
                        push_ev(K_RST, s + l, base, cut);
                        mode = 1;
                    end
                end
            end
            pos = pos + l;
        end
    endtask

    task automatic check_quiet(input string name);
        logic [4:0] p;
        p = {stuck_low, pres_err, no_presence, presence_found, reset_found};
        checks++;
        if (p != 5'b0) begin
            errors++;
            $display("FAIL %s outputs=%b required=00000", name, p);
        end
    endtask

    // act: 0 plain, 1 rst pulse at sample cut, 2 en_check low for 20 samples from cut.
    task automatic run_seq(input string name, input int cut, input int act);
        int base;
        int n;
        @(negedge clk);
        base = cyc;
        n    = 0;
        model(base, cut);
        for (int i = 0; i < segs.size(); i++) begin
            for (int j = 0; j < segs[i]; j++) begin
                bus = (i % 2 == 0);
                if (act == 1 && n == cut) rst = 1'b1;
                if (act == 1 && n == cut + 1) check_quiet({name, "_in_rst"});
                if (act == 1 && n == cut + 2) rst = 1'b0;
                if (act == 2 && n == cut) en_check = 1'b0;
                if (act == 2 && n == cut + 20) en_check = 1'b1;
                n++;
                @(negedge clk);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_pulses got=0 required=%0d (next kind %0d at cyc %0d)",
                     name, exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] p;
        exp_t e;
        p = {stuck_low, pres_err, no_presence, presence_found, reset_found};
        if (p != 5'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse got=%b at cyc %0d required=none", p, cyc);
            end else begin
                e = exp_q.pop_front();
                if (p != (5'b00001 << e.kind) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse got=%b at cyc %0d required=%b at cyc %0d",
                             p, cyc, 5'b00001 << e.kind, e.cyc);
                end
            end
        end
    end

    function automatic int pick_low();
        case ($urandom_range(0, 3))
            0: return $urandom_range(1, 100);
            1: return $urandom_range(470, 490);
            2: return $urandom_range(500, 900);
            default: return $urandom_range(950, 970);
        endcase
    endfunction

    function automatic int pick_gap();
        case ($urandom_range(0, 3))
            0: return $urandom_range(1, 20);
            1: return $urandom_range(13, 17);
            2: return $urandom_range(20, 59);
            default: return $urandom_range(58, 63);
        endcase
    endfunction

    function automatic int pick_pres();
        case ($urandom_range(0, 3))
            0: return $urandom_range(30, 70);
            1: return $urandom_range(55, 65);
            2: return $urandom_range(100, 230);
            default: return $urandom_range(235, 245);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus = 1'b1;
        en_check = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_state");
        rst = 1'b0;

        segs = {20, 500, 30, 120, 100};
        run_seq("reset_then_presence", NO_CUT, 0);
        segs = {20, 479, 50, 480, 100};
        run_seq("reset_min_boundary", NO_CUT, 0);
        segs = {20, 500, 100};
        run_seq("no_presence", NO_CUT, 0);
        segs = {20, 1000, 50, 500, 30, 120, 100};
        run_seq("stuck_then_recover", NO_CUT, 0);
        segs = {20, 500, 10, 100, 100};
        run_seq("presence_early", NO_CUT, 0);
        segs = {20, 500, 30, 40, 100};
        run_seq("presence_short", NO_CUT, 0);
        segs = {20, 500, 30, 300, 100};
        run_seq("presence_long", NO_CUT, 0);
        segs = {20, 500, 15, 60, 80, 500, 60, 240, 100};
        run_seq("presence_edges", NO_CUT, 0);

        // Disable at low sample 300; re-enable while still low: no fall, no pulse.
        segs = {10, 900, 100};
        run_seq("en_abort", 310, 2);
        // Reset during presence low: only the earlier reset_found is expected.
        segs = {10, 500, 30, 100, 100};
        run_seq("rst_mid_pres", 590, 1);
        segs = {20, 500, 30, 120, 100};
        run_seq("after_abort", NO_CUT, 0);

        for (int k = 0; k < 12; k++) begin
            segs = {};
            segs.push_back($urandom_range(1, 30));
            segs.push_back(pick_low());
            segs.push_back(pick_gap());
            segs.push_back(pick_pres());
            segs.push_back($urandom_range(1, 40));
            segs.push_back($urandom_range(1, 80));
            segs.push_back($urandom_range(61, 100));
            run_seq("random", NO_CUT, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
